// File: rtl/dla_debug_network_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dla_debug_network_pkg
// Brief    : Shared types and constants for the debug network ring nodes.
// Revision : 1.0 - initial release
// ============================================================================
package dla_debug_network_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } dla_dbg_port_state_e;

    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_D0D0;
    localparam int          CLOBBER_CNT_W   = 8;

endpackage
`default_nettype wire

// File: rtl/dla_debug_network_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dla_debug_network_resp_fifo
// Brief    : Response buffer; head entry is read straight from the storage registers.
// Revision : 1.0 - initial release
// ============================================================================
module dla_debug_network_resp_fifo
    import dla_debug_network_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  i_aresetn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int C_PTR_W = $clog2(RESP_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
    logic [C_PTR_W:0]      r_wr_ptr;
    logic [C_PTR_W:0]      r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full)
                r_wr_ptr <= r_wr_ptr + (C_PTR_W+1)'(1);
            if (i_pop && !o_empty)
                r_rd_ptr <= r_rd_ptr + (C_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_wr_ptr[C_PTR_W-1:0]] <= i_push_data;
    end

    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[C_PTR_W] != r_rd_ptr[C_PTR_W]) &&
                         (r_wr_ptr[C_PTR_W-1:0] == r_rd_ptr[C_PTR_W-1:0]);
    assign o_head_data = r_mem[r_rd_ptr[C_PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/dla_debug_network_multi_node.sv
`default_nettype none
// ============================================================================
// Module   : dla_debug_network_multi_node
// Brief    : Debug ring node serving NUM_PORTS AXI-lite read slaves from one hop.
//            Optional response timeout: define DLA_DEBUG_NODE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dla_debug_network_multi_node
    import dla_debug_network_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  ADDR_LOWER     = 24,
    parameter int  MODULE_ID_BASE = 0,
    parameter int  NUM_PORTS      = 4,
    parameter int  RESP_DEPTH     = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int BUS_WIDTH      = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             i_aresetn,
    input  logic                             i_up_forced_valid,
    input  logic [BUS_WIDTH-1:0]             i_up_shared_bus,
    input  logic                             i_up_is_addr,
    output logic                             o_down_forced_valid,
    output logic [BUS_WIDTH-1:0]             o_down_shared_bus,
    output logic                             o_down_is_addr,
    output logic [NUM_PORTS-1:0]             o_req_valid,
    output logic [NUM_PORTS*ADDR_LOWER-1:0]  o_req_addr,
    input  logic [NUM_PORTS-1:0]             i_req_ready,
    input  logic [NUM_PORTS-1:0]             i_resp_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_resp_data,
    output logic [NUM_PORTS-1:0]             o_resp_ready,
    output logic [CLOBBER_CNT_W-1:0]         o_clobber_count
);

    localparam int C_ID_W   = ADDR_WIDTH - ADDR_LOWER;
    localparam int C_PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [DATA_WIDTH-1:0] C_TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_PATTERN);

    logic [C_ID_W-1:0]      w_up_id;
    logic                   w_up_addr_valid;
    logic [NUM_PORTS-1:0]   w_decode;
    logic [NUM_PORTS-1:0]   w_busy;
    logic [NUM_PORTS-1:0]   w_req;
    logic [NUM_PORTS-1:0]   w_grant;
    logic [NUM_PORTS-1:0]   w_done;
    logic [C_PORT_W-1:0]    w_grant_idx;
    logic [DATA_WIDTH-1:0]  w_port_data [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  w_head_data;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_clobber;
    logic [C_PORT_W-1:0]    r_last;
    logic [CLOBBER_CNT_W-1:0] r_clobber_cnt;
    logic                   r_down_valid;
    logic [BUS_WIDTH-1:0]   r_down_bus;
    logic                   r_down_is_addr;

    assign w_up_id         = i_up_shared_bus[ADDR_WIDTH-1:ADDR_LOWER];
    assign w_up_addr_valid = i_up_forced_valid && i_up_is_addr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [31:0] C_PORT_ID = 32'(MODULE_ID_BASE + p);

        dla_dbg_port_state_e    r_state;
        dla_dbg_port_state_e    w_next_state;
        logic [ADDR_LOWER-1:0]  r_addr;
        logic                   w_is_req;
        logic                   w_is_wait;
        logic                   w_timed_out;

        assign w_decode[p] = w_up_addr_valid && (32'(w_up_id) == C_PORT_ID);

        always_ff @(posedge clk or negedge i_aresetn) begin
            if (!i_aresetn)
                r_state <= IDLE;
            else
                r_state <= w_next_state;
        end

        // A decode always restarts the port, even on the cycle a response is accepted.
        always_comb begin
            w_next_state = r_state;
            case (r_state)
                IDLE:      w_next_state = IDLE;
                REQ:       if (i_req_ready[p]) w_next_state = WAIT_RESP;
                WAIT_RESP: if (w_done[p])      w_next_state = IDLE;
                default:   w_next_state = IDLE;
            endcase
            if (w_decode[p])
                w_next_state = REQ;
        end

        always_comb begin
            w_is_req  = 1'b0;
            w_is_wait = 1'b0;
            case (r_state)
                REQ:       w_is_req  = 1'b1;
                WAIT_RESP: w_is_wait = 1'b1;
                default:   ;
            endcase
        end

        always_ff @(posedge clk or negedge i_aresetn) begin
            if (!i_aresetn)
                r_addr <= '0;
            else if (w_decode[p])
                r_addr <= i_up_shared_bus[ADDR_LOWER-1:0];
        end

`ifdef DLA_DEBUG_NODE_TIMEOUT_EN
        localparam int C_TO_W = $clog2(TIMEOUT_CYCLES);
        logic [C_TO_W-1:0] r_wait_cnt;

        // Saturates so a timed-out port keeps bidding until the arbiter serves it.
        always_ff @(posedge clk or negedge i_aresetn) begin
            if (!i_aresetn)
                r_wait_cnt <= '0;
            else if (!w_is_wait)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != C_TO_W'(TIMEOUT_CYCLES-1))
                r_wait_cnt <= r_wait_cnt + C_TO_W'(1);
        end

        assign w_timed_out = w_is_wait && (r_wait_cnt == C_TO_W'(TIMEOUT_CYCLES-1));
`else
        assign w_timed_out = 1'b0;
`endif

        assign w_busy[p]      = (r_state != IDLE);
        assign w_req[p]       = w_is_wait && (i_resp_valid[p] || w_timed_out);
        assign w_port_data[p] = i_resp_valid[p] ? i_resp_data[p*DATA_WIDTH +: DATA_WIDTH]
                                                : C_TIMEOUT_DATA;
        assign o_req_valid[p] = w_is_req;
        assign o_resp_ready[p] = w_is_wait && w_grant[p] && !w_full;
        assign o_req_addr[p*ADDR_LOWER +: ADDR_LOWER] = r_addr;
    end

    // Round-robin: search starts one past the previous winner.
    always_comb begin
        int  w_idx;
        logic w_found;
        w_grant     = '0;
        w_grant_idx = r_last;
        w_idx       = 0;
        w_found     = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = (int'(r_last) + i) % NUM_PORTS;
            if (!w_found && w_req[C_PORT_W'(w_idx)]) begin
                w_found                   = 1'b1;
                w_grant[C_PORT_W'(w_idx)] = 1'b1;
                w_grant_idx               = C_PORT_W'(w_idx);
            end
        end
    end

    assign w_done    = w_grant & {NUM_PORTS{!w_full}};
    assign w_push    = |(w_done & ~w_decode);
    assign w_pop     = !w_empty && !i_up_forced_valid;
    assign w_clobber = |(w_decode & w_busy);

    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn)
            r_last <= C_PORT_W'(NUM_PORTS-1);
        else if (|w_done)
            r_last <= w_grant_idx;
    end

    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn)
            r_clobber_cnt <= '0;
        else if (w_clobber && (r_clobber_cnt != '1))
            r_clobber_cnt <= r_clobber_cnt + CLOBBER_CNT_W'(1);
    end

    dla_debug_network_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .i_aresetn   (i_aresetn),
        .i_push      (w_push),
        .i_push_data (w_port_data[w_grant_idx]),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Upstream traffic owns the slot; buffered responses fill only idle slots.
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_down_valid   <= 1'b0;
            r_down_bus     <= '0;
            r_down_is_addr <= 1'b0;
        end else if (i_up_forced_valid) begin
            r_down_valid   <= 1'b1;
            r_down_bus     <= i_up_shared_bus;
            r_down_is_addr <= i_up_is_addr;
        end else begin
            r_down_valid   <= w_pop;
            r_down_bus     <= w_pop ? BUS_WIDTH'(w_head_data) : '0;
            r_down_is_addr <= 1'b0;
        end
    end

    assign o_down_forced_valid = r_down_valid;
    assign o_down_shared_bus   = r_down_bus;
    assign o_down_is_addr      = r_down_is_addr;
    assign o_clobber_count     = r_clobber_cnt;

endmodule
`default_nettype wire
